// File: rtl/scan_bcd_mux.sv
// Four-digit multiplexed display scanner: drives 74HC138 address and 74HC4511 BCD nibble
// per digit slot, with ghost-blank gaps, leading-zero blanking and a tear-free input buffer.
module scan_bcd_mux #(
    parameter int unsigned DIV   = 1000,
    parameter int unsigned BLANK = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic        lzb_en,
    output logic [2:0]  A,
    output logic [3:0]  INn,
    output logic        frame_tick
);
    localparam int unsigned CNT_W = 16;
    localparam int unsigned DIG_W = 2;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [2:0]       A_NONE    = 3'd7;
    localparam logic [3:0]       BCD_BLANK = 4'hF;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIG_W-1:0] dig_q, dig_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pbuf_q, pbuf_d;
    logic             pending_q, pending_d;
    logic [2:0]       a_q, a_d;
    logic [3:0]       inn_q, inn_d;
    logic             tick_q, tick_d;
    logic             slot_end, frame_start, take, gap, lz_blank;
    logic [3:0]       nib_zero;

    assign din_ready  = !pending_q;
    assign A          = a_q;
    assign INn        = inn_q;
    assign frame_tick = tick_q;

    // GAP phase of a slot, judged on the post-edge counter
    generate
        if (BLANK == 0) begin : g_no_gap
            assign gap = 1'b0;
        end else begin : g_gap
            assign gap = (cnt_d < CNT_W'(BLANK));
        end
    endgenerate

    // Slot/digit sequencing
    always_comb begin
        slot_end    = (cnt_q == CNT_LAST);
        frame_start = slot_end && (dig_q == DIG_W'(3));
        cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
        dig_d       = slot_end ? dig_q + DIG_W'(1) : dig_q;
    end

    // Input buffer; a word taken on a frame-start edge waits for the next frame
    always_comb begin
        take      = din_valid && !pending_q;
        disp_d    = disp_q;
        pbuf_d    = pbuf_q;
        pending_d = pending_q;
        if (frame_start && pending_q) begin
            disp_d    = pbuf_q;
            pending_d = 1'b0;
        end
        if (take) begin
            pbuf_d    = din;
            pending_d = 1'b1;
        end
    end

    // Output mapping from post-edge slot state
    always_comb begin
        a_d      = A_NONE;
        inn_d    = BCD_BLANK;
        tick_d   = frame_start;
        lz_blank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nib_zero[k] = (disp_d[4*k +: 4] == 4'h0);
        end
        case (dig_d)
            2'd3:    lz_blank = nib_zero[3];
            2'd2:    lz_blank = &nib_zero[3:2];
            2'd1:    lz_blank = &nib_zero[3:1];
            default: lz_blank = 1'b0;
        endcase
        if (!gap) begin
            a_d   = {1'b0, dig_d};
            inn_d = (lz_blank && lzb_en) ? BCD_BLANK : disp_d[{dig_d, 2'b00} +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            disp_q    <= '0;
            pbuf_q    <= '0;
            pending_q <= 1'b0;
            a_q       <= A_NONE;
            inn_q     <= BCD_BLANK;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            disp_q    <= disp_d;
            pbuf_q    <= pbuf_d;
            pending_q <= pending_d;
            a_q       <= a_d;
            inn_q     <= inn_d;
            tick_q    <= tick_d;
        end
    end

endmodule
